// File: rtl/mac_dot_sequencer.sv
// Operand sequencer for a latency-MAC_LAT multiply-accumulate core: buffers (a,b) pairs,
// issues them one at a time, and returns one dot product per job. Define MAC_SEQ_OVF_EN for overflow flagging.
`timescale 1ns/1ps
module mac_dot_sequencer #(
  parameter int DW         = 16,
  parameter int AW         = 32,
  parameter int MAC_LAT    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic [AW-1:0]    init_acc,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_a,
  input  logic [DW-1:0]    in_b,
  output logic [DW-1:0]    mac_a,
  output logic [DW-1:0]    mac_b,
  output logic [AW-1:0]    mac_acc_in,
  input  logic [AW-1:0]    mac_acc_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [AW-1:0]    res_data,
  output logic             res_ovf,
  output logic             busy
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int WCW = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [DW-1:0]    r_fifo_a [FIFO_DEPTH];
  logic [DW-1:0]    r_fifo_b [FIFO_DEPTH];
  logic [PW:0]      r_wr_ptr, r_rd_ptr;
  logic [LEN_W-1:0] r_count;
  logic [WCW-1:0]   r_wait_cnt;
  logic [AW-1:0]    r_acc;
  logic             w_full, w_empty, w_push, w_pop, w_wait_done, w_start;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_push      = in_valid && !w_full;
  assign w_pop       = (r_state == S_ISSUE) && !w_empty;
  assign w_start     = (r_state == S_IDLE) && start;
  assign w_wait_done = (r_state == S_WAIT) && (r_wait_cnt == WCW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_a[r_wr_ptr[PW-1:0]] <= in_a;
      r_fifo_b[r_wr_ptr[PW-1:0]] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // NOTE: w_next gets its default before the case so no path can leave it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (vec_len == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (!w_empty) w_next = S_WAIT;
      S_WAIT:  if (w_wait_done) w_next = (r_count == '0) ? S_DONE : S_ISSUE;
      S_DONE:  if (res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count    <= '0;
      r_wait_cnt <= '0;
      r_acc      <= '0;
    end else begin
      if (w_start) begin
        r_count <= vec_len;
        r_acc   <= init_acc;
      end
      if (w_pop) begin
        r_count    <= r_count - 1'b1;
        r_wait_cnt <= WCW'(MAC_LAT);
      end
      if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt - 1'b1;
      if (w_wait_done) r_acc <= mac_acc_out;
    end
  end

`ifdef MAC_SEQ_OVF_EN
  logic r_ovf, r_prod_sign, r_prod_nz, w_ovf_step;

  // r_acc still holds the issued acc_in throughout WAIT, so its MSB is the acc_in sign.
  assign w_ovf_step = r_prod_nz && (r_acc[AW-1] == r_prod_sign) &&
                      (mac_acc_out[AW-1] != r_acc[AW-1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf       <= 1'b0;
      r_prod_sign <= 1'b0;
      r_prod_nz   <= 1'b0;
    end else begin
      if (w_start) r_ovf <= 1'b0;
      if (w_pop) begin
        r_prod_sign <= r_fifo_a[r_rd_ptr[PW-1:0]][DW-1] ^ r_fifo_b[r_rd_ptr[PW-1:0]][DW-1];
        r_prod_nz   <= (r_fifo_a[r_rd_ptr[PW-1:0]] != '0) && (r_fifo_b[r_rd_ptr[PW-1:0]] != '0);
      end
      if (w_wait_done && w_ovf_step) r_ovf <= 1'b1;
    end
  end

  assign res_ovf = r_ovf;
`else
  assign res_ovf = 1'b0;
`endif

  assign in_ready   = !w_full;
  assign mac_a      = w_pop ? r_fifo_a[r_rd_ptr[PW-1:0]] : '0;
  assign mac_b      = w_pop ? r_fifo_b[r_rd_ptr[PW-1:0]] : '0;
  assign mac_acc_in = r_acc;
  assign res_valid  = (r_state == S_DONE);
  assign res_data   = r_acc;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Self-checking bench for mac_dot_sequencer: vector table, multi-cycle corner sequences,
// and randomized jobs against a queue-based arithmetic reference model.
`timescale 1ns/1ps
module tb_mac_dot_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  vec_len = '0;
  logic [31:0] init_acc = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0, in_b = '0;
  logic [15:0] mac_a, mac_b;
  logic [31:0] mac_acc_in;
  logic [31:0] mac_acc_out = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_ovf;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];

  typedef struct packed {
    logic [7:0]       len;
    logic [31:0]      init;
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [31:0]      exp_data;
    logic             exp_ovf;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  mac_dot_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .init_acc(init_acc),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_acc_in(mac_acc_in), .mac_acc_out(mac_acc_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_ovf(res_ovf), .busy(busy)
  );

  // Core model with one cycle of latency: acc_out <= acc_in + a*b.
  logic signed [31:0] mac_prod;
  assign mac_prod = $signed(mac_a) * $signed(mac_b);
  always @(posedge clk) mac_acc_out <= mac_acc_in + mac_prod;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Dot product over the first len queued pairs, with overflow defined as leaving the 32-bit signed range.
  function automatic void model(input int len, input logic [31:0] init,
                                output logic [31:0] d, output logic o);
    longint acc, s;
    acc = longint'($signed(init));
    o = 1'b0;
    for (int i = 0; i < len && i < qa.size(); i++) begin
      s = acc + longint'($signed(qa[i])) * longint'($signed(qb[i]));
      if (s > 64'sd2147483647 || s < -64'sd2147483648) o = 1'b1;
      acc = longint'($signed(s[31:0]));
    end
    d = acc[31:0];
  endfunction

  function automatic logic ovf_expected(input logic o);
`ifdef MAC_SEQ_OVF_EN
    return o;
`else
    return 1'b0 & o;
`endif
  endfunction

  task automatic consume(input int len);
    for (int i = 0; i < len && qa.size() > 0; i++) begin
      void'(qa.pop_front());
      void'(qb.pop_front());
    end
  endtask

  task automatic set_vec(input int idx, input int len, input logic [31:0] init,
                         input int a0, input int b0, input int a1, input int b1,
                         input int a2, input int b2, input int a3, input int b3,
                         input logic [31:0] ed, input logic eo);
    tbl[idx].len = 8'(len);
    tbl[idx].init = init;
    tbl[idx].a[0] = 16'(a0); tbl[idx].b[0] = 16'(b0);
    tbl[idx].a[1] = 16'(a1); tbl[idx].b[1] = 16'(b1);
    tbl[idx].a[2] = 16'(a2); tbl[idx].b[2] = 16'(b2);
    tbl[idx].a[3] = 16'(a3); tbl[idx].b[3] = 16'(b3);
    tbl[idx].exp_data = ed;
    tbl[idx].exp_ovf = eo;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    logic acc;
    in_valid = 1'b1; in_a = a; in_b = b;
    acc = in_ready;
    tick();
    in_valid = 1'b0;
    if (acc) begin
      qa.push_back(a);
      qb.push_back(b);
    end
  endtask

  task automatic start_job(input int len, input logic [31:0] init);
    start = 1'b1; vec_len = 8'(len); init_acc = init;
    tick();
    start = 1'b0;
  endtask

  // Called right after the start edge; latency counts the start cycle as 1.
  task automatic wait_result(input string name, input logic [31:0] ed, input logic eo,
                             input int exp_lat, input int hold);
    int lat = 1;
    while (!res_valid && lat < 3000) begin
      tick();
      lat++;
    end
    check({name, "_valid"}, 32'(res_valid), 32'd1);
    if (res_valid) begin
      check({name, "_data"}, res_data, ed);
      check({name, "_ovf"}, 32'(res_ovf), 32'(eo));
      if (exp_lat > 0) check({name, "_latency"}, lat, exp_lat);
      for (int i = 0; i < hold; i++) begin
        tick();
        check({name, "_hold_valid"}, 32'(res_valid), 32'd1);
        check({name, "_hold_data"}, res_data, ed);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check({name, "_released"}, {30'd0, res_valid, busy}, 32'd0);
    end
  endtask

  // Job with an empty FIFO at start; pairs trickle in while the sequencer runs.
  task automatic run_stream(input string name, input int len, input logic [31:0] init,
                            input int gap, input bit poke_start, input int hold);
    logic [15:0] pa[12], pb[12];
    logic [31:0] d;
    logic o, acc;
    int idx = 0, cyc = 0;
    for (int i = 0; i < 12; i++) begin
      pa[i] = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      pb[i] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
    end
    start_job(len, init);
    while (!res_valid && cyc < 3000) begin
      in_valid = (idx < len) && ((gap > 0) ? (cyc % gap == 0) : ($urandom_range(0, 2) != 0));
      in_a = pa[idx % 12]; in_b = pb[idx % 12];
      start = poke_start && (cyc == 3);
      vec_len = 8'd9;
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        qa.push_back(in_a);
        qb.push_back(in_b);
        idx++;
      end
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0;
    model(len, init, d, o);
    consume(len);
    wait_result(name, d, ovf_expected(o), 0, hold);
  endtask

  initial begin
    logic [31:0] d;
    logic o, acc;
    int n_acc;

    set_vec(0, 3, 32'd10, 1, 2, 3, 4, -5, 6, 0, 0, 32'hFFFF_FFFA, 1'b0);
    set_vec(1, 0, 32'h0000_1234, 9, 9, 9, 9, 9, 9, 9, 9, 32'h0000_1234, 1'b0);
    set_vec(2, 1, 32'h7FFF_FFF0, 4, 4, 0, 0, 0, 0, 0, 0, 32'h8000_0000, 1'b1);
    set_vec(3, 2, 32'd0, -1, -1, 100, -3, 0, 0, 0, 0, 32'hFFFF_FED5, 1'b0);
    set_vec(4, 2, 32'h8000_0000, -32768, 32767, 0, 5, 0, 0, 0, 0, 32'h4000_8000, 1'b1);

    #2;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_mac_ab", {mac_a, mac_b}, 32'd0);
    check("reset_res_data", res_data, 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Reset in the middle of a job while the FIFO still holds three pairs.
    for (int i = 0; i < 4; i++) push(16'(i + 1), 16'(i + 3));
    start_job(8, 32'd100);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_res_valid", 32'(res_valid), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    check("midreset_mac_ab", {mac_a, mac_b}, 32'd0);
    check("midreset_acc", mac_acc_in, 32'd0);
    tick(); tick();
    rst = 1'b1;
    qa.delete(); qb.delete();
    start_job(1, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("flush_starved_busy", 32'(busy), 32'd1);
      check("flush_starved_mac_ab", {mac_a, mac_b}, 32'd0);
      tick();
    end
    push(16'd2, 16'd3);
    consume(1);
    wait_result("flush_job", 32'd6, 1'b0, 0, 0);

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < int'(tbl[i].len); j++) push(tbl[i].a[j], tbl[i].b[j]);
      start_job(int'(tbl[i].len), tbl[i].init);
      wait_result($sformatf("vec%0d", i), tbl[i].exp_data, ovf_expected(tbl[i].exp_ovf),
                  1 + 2 * int'(tbl[i].len), 0);
      consume(int'(tbl[i].len));
    end

    // A zero-length job must leave preloaded operands for the next job.
    push(16'd5, 16'd7);
    start_job(0, 32'h0000_1234);
    wait_result("zero_len", 32'h0000_1234, 1'b0, 1, 0);
    start_job(1, 32'd0);
    wait_result("after_zero", 32'd35, 1'b0, 3, 0);
    consume(1);

    // Six back-to-back pushes into an idle sequencer.
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_a = 16'(i + 1); in_b = 16'(i + 2);
      acc = in_ready;
      tick();
      if (acc) begin
        qa.push_back(in_a); qb.push_back(in_b); n_acc++;
      end
    end
    in_valid = 1'b0;
    check("full_accepted", n_acc, 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    model(4, 32'd0, d, o);
    consume(4);
    start_job(4, 32'd0);
    wait_result("full_drain", d, ovf_expected(o), 9, 0);

    run_stream("starve_bp", 4, 32'h0000_0100, 5, 1'b1, 10);

    for (int k = 0; k < 30; k++)
      run_stream($sformatf("rand%0d", k), $urandom_range(0, 12),
                 ($urandom_range(0, 2) == 0) ? 32'h7FFF_0000 : $urandom, 0, 1'b0,
                 $urandom_range(0, 3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
